cook_timer_sequencer: RTL and testbench
=======================================

Name: cook_timer_sequencer

Overview:
Sequences the microwave cook timer. It collects keypad digits into an MM:SS BCD time and counts that time down on the 1 Hz tick while the magnetron is enabled. It handles pause on door-open or stop, and drives the end-of-cook beep. It sits between the input-control front end (debounced keys, tick generator) and the display and magnetron drivers.

Parameters:
QUICK_SEC, 8'h30, BCD seconds loaded by a quick-start (start pressed in IDLE with time 00:00)
DONE_BEEP_TICKS, 3, number of tick strobes the beep stays high in DONE
HOLD_CYCLES, 4, consecutive clk cycles with stop high that force a full clear (long press)

Ports:
clk  in  1  system clock; all state changes on the rising edge
clear  in  1  synchronous, active-high reset
tick  in  1  one-cycle 1 Hz strobe
key_valid  in  1  one-cycle strobe qualifying key_digit
key_digit  in  4  BCD digit; values above 9 are ignored
start  in  1  one-cycle strobe
stop  in  1  level, high while the stop button is held
door_open  in  1  level, high while the door is open
time_bcd  out  16  {min_tens, min_ones, sec_tens, sec_ones}
mag_on  out  1  magnetron enable
beep  out  1  buzzer enable
state_o  out  3  current state encoding

Behaviour:
- Reset: when clear=1 at a clk edge, state goes to IDLE and time_bcd, mag_on, beep, the beep counter, the hold counter and the stop edge register all go to 0. clear has priority over every other input.
- State encoding: IDLE=0, ENTRY=1, COOK=2, PAUSE=3, DONE=4. Codes 5-7 are illegal and return to IDLE with time cleared.
- Per-edge priority after clear: long-press > door_open > stop rising edge > tick > start > key_valid.
- Long press:
  - The hold counter increments every cycle stop=1 and zeroes when stop=0. It saturates and does not wrap.
  - When the counter reaches HOLD_CYCLES (the edge where the HOLD_CYCLES-th consecutive high cycle is sampled), the block goes to IDLE and time goes to 0, from any state.
- Stop rising edge (stop=1 while the registered previous stop=0):
  - In COOK, go to PAUSE with time held.
  - In ENTRY, PAUSE or DONE, go to IDLE with time cleared.
  - In IDLE, no effect.
- Key entry:
  - Applies only in IDLE or ENTRY, for a key_valid with key_digit<=9.
  - time_bcd <= {time_bcd[11:0], key_digit}; state goes to ENTRY.
  - Digits above 9 are ignored. All keys are ignored in COOK, PAUSE and DONE.
- Start:
  - In ENTRY or PAUSE with door_open=0 and time nonzero, go to COOK.
  - In IDLE with time 00:00 and door_open=0, load 16'h00 & QUICK_SEC and go to COOK.
  - In all other cases start is ignored, including ENTRY with time 00:00 and any state with the door open.
- Door:
  - door_open=1 in COOK sends the block to PAUSE on that edge.
  - In other states door_open only blocks start.
- Countdown:
  - In COOK, each tick applies a BCD decrement of the MM:SS value.
  - sec_ones 0 borrows from sec_tens. sec_tens:sec_ones of 00 borrows a minute and reloads 59. min_ones 0 borrows from min_tens.
  - Seconds above 59 entered by the user (e.g. 1:90) count down literally, 90→89…, with no normalisation.
  - A tick that takes the time to 00:00 moves the block to DONE on the same edge.
- mag_on: registered; 1 exactly when the next state is COOK. It drops on the same edge that leaves COOK, so it has 0-cycle lag relative to state_o.
- DONE:
  - beep=1 from entry into DONE, and time stays 00:00.
  - The beep counter counts ticks. On the DONE_BEEP_TICKS-th tick, beep goes to 0 and state goes to IDLE.
  - start and keys are ignored in DONE.
- Range: the maximum time is 99:99. There is no overflow, because entry only shifts and the fifth digit pushes out min_tens.

Decomposition:
- Shared package: state encoding constants, the QUICK_SEC default, and a BCD 4-digit decrement function (also reused by the display formatter).
- One sub-module: press_hold_qualifier (clk, clear, stop → stop_rise, stop_long). It holds the stop edge register and the saturating HOLD_CYCLES counter.

Test Plan:
- Reset, then keys 1,3,0 and start with the door closed → time_bcd=16'h0130 and state ENTRY before start, then COOK with mag_on=1; after 31 ticks time_bcd=16'h0059.
- From 16'h0002 in COOK, two ticks → after the first tick 16'h0001; on the second tick time becomes 16'h0000, state DONE, mag_on=0, beep=1. After 3 more ticks beep=0 and state IDLE.
- In COOK with 16'h0045, door_open=1 → PAUSE, mag_on=0, time holds through ticks. Start with the door still open is ignored. Door closed then start → COOK resumes at 16'h0045.
- Start in IDLE at 00:00 → time_bcd=16'h0030, COOK. A stop pulse of 1 cycle → PAUSE. A second 1-cycle pulse → IDLE with time 0.
- With stop held 4 cycles in COOK → PAUSE after cycle 1, then IDLE with time cleared at cycle 4. clear asserted mid-COOK → all outputs 0 on the next edge.
- Keys 9,9,9,9,5 → 16'h9995. key_digit=4'hA is ignored. In COOK with 16'h0100, one tick → 16'h0059. Start in ENTRY with 16'h0000 → stays ENTRY.

Source files
------------

// File: rtl/cook_timer_sequencer_pkg.sv
// Shared definitions for the microwave cook timer: state codes, defaults and
// the MM:SS BCD countdown step also used by the display formatter.
package cook_timer_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ENTRY = 3'd1,
        ST_COOK  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [7:0] QUICK_SEC_DEFAULT       = 8'h30;
    localparam int         DONE_BEEP_TICKS_DEFAULT = 3;
    localparam int         HOLD_CYCLES_DEFAULT     = 4;

    // One-second BCD decrement of {min_tens, min_ones, sec_tens, sec_ones}.
    // Seconds above 59 count down literally; 00:00 stays 00:00.
    function automatic logic [15:0] bcd_dec4(input logic [15:0] t);
        logic [3:0] mt;
        logic [3:0] mo;
        logic [3:0] st;
        logic [3:0] so;
        {mt, mo, st, so} = t;
        if (so != 4'd0) begin
            so = so - 4'd1;
        end else if (st != 4'd0) begin
            st = st - 4'd1;
            so = 4'd9;
        end else if (mo != 4'd0) begin
            mo = mo - 4'd1;
            st = 4'd5;
            so = 4'd9;
        end else if (mt != 4'd0) begin
            mt = mt - 4'd1;
            mo = 4'd9;
            st = 4'd5;
            so = 4'd9;
        end
        return {mt, mo, st, so};
    endfunction

endpackage

// File: rtl/cook_timer_sequencer_press_hold_qualifier.sv
// Qualifies the stop button: a rising-edge strobe and a one-shot long-press
// strobe on the cycle the HOLD_CYCLES-th consecutive high sample is taken.
module press_hold_qualifier #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic clear,
    input  logic stop,
    output logic stop_rise,
    output logic stop_long
);

    localparam int             CW        = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0]  HOLD_MAX  = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0]  HOLD_LAST = CW'(HOLD_CYCLES - 1);

    logic [CW-1:0] hold_cnt_reg;
    logic          stop_prev_reg;

    always_ff @(posedge clk) begin
        if (clear) begin
            hold_cnt_reg  <= '0;
            stop_prev_reg <= 1'b0;
        end else begin
            stop_prev_reg <= stop;
            if (!stop) begin
                hold_cnt_reg <= '0;
            end else if (hold_cnt_reg != HOLD_MAX) begin
                hold_cnt_reg <= hold_cnt_reg + 1'b1;
            end
        end
    end

    assign stop_rise = stop && !stop_prev_reg;
    // Fires only on the edge that moves the counter onto HOLD_MAX; saturation keeps it single-shot.
    assign stop_long = stop && (hold_cnt_reg == HOLD_LAST);

endmodule

// File: rtl/cook_timer_sequencer.sv
// Microwave cook timer: keypad MM:SS entry, 1 Hz BCD countdown with pause on
// door/stop, quick-start, long-press clear and end-of-cook beep.
module cook_timer_sequencer
    import cook_timer_sequencer_pkg::*;
#(
    parameter logic [7:0] QUICK_SEC       = QUICK_SEC_DEFAULT,
    parameter int         DONE_BEEP_TICKS = DONE_BEEP_TICKS_DEFAULT,
    parameter int         HOLD_CYCLES     = HOLD_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        clear,
    input  logic        tick,
    input  logic        key_valid,
    input  logic [3:0]  key_digit,
    input  logic        start,
    input  logic        stop,
    input  logic        door_open,
    output logic [15:0] time_bcd,
    output logic        mag_on,
    output logic        beep,
    output logic [2:0]  state_o
);

    localparam int            BW        = $clog2(DONE_BEEP_TICKS + 1);
    localparam logic [BW-1:0] BEEP_LAST = BW'(DONE_BEEP_TICKS - 1);

    state_t        state_reg;
    logic [15:0]   time_reg;
    logic          mag_on_reg;
    logic          beep_reg;
    logic [BW-1:0] beep_cnt_reg;

    logic          stop_rise;
    logic          stop_long;
    logic [15:0]   time_dec;
    logic          key_ok;
    logic          start_ok;
    logic          time_zero;

    press_hold_qualifier #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_stop_qual (
        .clk       (clk),
        .clear     (clear),
        .stop      (stop),
        .stop_rise (stop_rise),
        .stop_long (stop_long)
    );

    assign time_dec  = bcd_dec4(time_reg);
    assign key_ok    = key_valid && (key_digit <= 4'd9);
    assign start_ok  = start && !door_open;
    assign time_zero = (time_reg == 16'h0000);

    // mag_on/beep are set on the very edge that enters or leaves COOK/DONE,
    // so they always track state_o without lag.
    always_ff @(posedge clk) begin
        if (clear || stop_long) begin
            state_reg    <= ST_IDLE;
            time_reg     <= 16'h0000;
            mag_on_reg   <= 1'b0;
            beep_reg     <= 1'b0;
            beep_cnt_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start_ok && time_zero) begin
                        state_reg  <= ST_COOK;
                        time_reg   <= {8'h00, QUICK_SEC};
                        mag_on_reg <= 1'b1;
                    end else if (key_ok) begin
                        state_reg <= ST_ENTRY;
                        time_reg  <= {time_reg[11:0], key_digit};
                    end
                end
                ST_ENTRY: begin
                    if (stop_rise) begin
                        state_reg <= ST_IDLE;
                        time_reg  <= 16'h0000;
                    end else if (start_ok && !time_zero) begin
                        state_reg  <= ST_COOK;
                        mag_on_reg <= 1'b1;
                    end else if (key_ok) begin
                        time_reg <= {time_reg[11:0], key_digit};
                    end
                end
                ST_COOK: begin
                    if (door_open || stop_rise) begin
                        state_reg  <= ST_PAUSE;
                        mag_on_reg <= 1'b0;
                    end else if (tick) begin
                        time_reg <= time_dec;
                        if (time_dec == 16'h0000) begin
                            state_reg    <= ST_DONE;
                            mag_on_reg   <= 1'b0;
                            beep_reg     <= 1'b1;
                            beep_cnt_reg <= '0;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (stop_rise) begin
                        state_reg <= ST_IDLE;
                        time_reg  <= 16'h0000;
                    end else if (start_ok && !time_zero) begin
                        state_reg  <= ST_COOK;
                        mag_on_reg <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (stop_rise) begin
                        state_reg    <= ST_IDLE;
                        time_reg     <= 16'h0000;
                        beep_reg     <= 1'b0;
                        beep_cnt_reg <= '0;
                    end else if (tick) begin
                        if (beep_cnt_reg == BEEP_LAST) begin
                            state_reg    <= ST_IDLE;
                            beep_reg     <= 1'b0;
                            beep_cnt_reg <= '0;
                        end else begin
                            beep_cnt_reg <= beep_cnt_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg    <= ST_IDLE;
                    time_reg     <= 16'h0000;
                    mag_on_reg   <= 1'b0;
                    beep_reg     <= 1'b0;
                    beep_cnt_reg <= '0;
                end
            endcase
        end
    end

    assign time_bcd = time_reg;
    assign mag_on   = mag_on_reg;
    assign beep     = beep_reg;
    assign state_o  = state_reg;

endmodule

// File: tb/tb_cook_timer_sequencer.sv
// Directed scenarios plus a randomized run checked against a behavioural
// minutes/seconds model of the cook timer.
module tb_cook_timer_sequencer;

    localparam int S_IDLE  = 0;
    localparam int S_ENTRY = 1;
    localparam int S_COOK  = 2;
    localparam int S_PAUSE = 3;
    localparam int S_DONE  = 4;
    localparam int HOLD    = 4;
    localparam int BEEPS   = 3;

    logic        clk = 1'b0;
    logic        clear = 1'b0;
    logic        tick = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_digit = 4'd0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        door_open = 1'b0;
    logic [15:0] time_bcd;
    logic        mag_on;
    logic        beep;
    logic [2:0]  state_o;

    int tests = 0;
    int fails = 0;
    bit door_lvl = 1'b0;

    // Behavioural model: time kept as plain minutes and seconds integers.
    int m_state = S_IDLE;
    int m_mm = 0;
    int m_ss = 0;
    int m_run = 0;
    bit m_prev = 1'b0;
    int m_beeps = 0;

    cook_timer_sequencer dut (
        .clk       (clk),
        .clear     (clear),
        .tick      (tick),
        .key_valid (key_valid),
        .key_digit (key_digit),
        .start     (start),
        .stop      (stop),
        .door_open (door_open),
        .time_bcd  (time_bcd),
        .mag_on    (mag_on),
        .beep      (beep),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    task automatic model_idle_clear();
        m_state = S_IDLE;
        m_mm = 0;
        m_ss = 0;
    endtask

    task automatic model_edge(input bit clr, input bit tk, input bit kv, input logic [3:0] kd,
                              input bit st, input bit sp, input bit dr);
        bit rise;
        int v;
        if (clr) begin
            model_idle_clear();
            m_run = 0;
            m_prev = 1'b0;
            m_beeps = 0;
            return;
        end
        rise = sp && !m_prev;
        m_prev = sp;
        m_run = sp ? m_run + 1 : 0;
        if (m_run == HOLD) begin
            model_idle_clear();
            return;
        end
        case (m_state)
            S_IDLE, S_ENTRY: begin
                if (m_state == S_ENTRY && rise) begin
                    model_idle_clear();
                end else if (st && !dr && m_state == S_IDLE && m_mm == 0 && m_ss == 0) begin
                    m_ss = 30;
                    m_state = S_COOK;
                end else if (st && !dr && m_state == S_ENTRY && (m_mm != 0 || m_ss != 0)) begin
                    m_state = S_COOK;
                end else if (kv && kd <= 4'd9) begin
                    v = ((m_mm * 100 + m_ss) * 10 + int'(kd)) % 10000;
                    m_mm = v / 100;
                    m_ss = v % 100;
                    m_state = S_ENTRY;
                end
            end
            S_COOK: begin
                if (dr || rise) begin
                    m_state = S_PAUSE;
                end else if (tk) begin
                    if (m_ss > 0) m_ss = m_ss - 1;
                    else begin
                        m_mm = m_mm - 1;
                        m_ss = 59;
                    end
                    if (m_mm == 0 && m_ss == 0) begin
                        m_state = S_DONE;
                        m_beeps = 0;
                    end
                end
            end
            S_PAUSE: begin
                if (rise) model_idle_clear();
                else if (st && !dr) m_state = S_COOK;
            end
            S_DONE: begin
                if (rise) model_idle_clear();
                else if (tk) begin
                    m_beeps = m_beeps + 1;
                    if (m_beeps == BEEPS) m_state = S_IDLE;
                end
            end
            default: model_idle_clear();
        endcase
    endtask

    function automatic logic [15:0] model_time();
        return {4'(m_mm / 10), 4'(m_mm % 10), 4'(m_ss / 10), 4'(m_ss % 10)};
    endfunction

    task automatic step(input bit clr, input bit tk, input bit kv, input logic [3:0] kd,
                        input bit st, input bit sp, input bit dr);
        clear = clr;
        tick = tk;
        key_valid = kv;
        key_digit = kd;
        start = st;
        stop = sp;
        door_open = dr;
        @(posedge clk);
        model_edge(clr, tk, kv, kd, st, sp, dr);
        #1;
    endtask

    task automatic do_clear();           step(1, 0, 0, 4'd0, 0, 0, door_lvl); endtask
    task automatic idle();               step(0, 0, 0, 4'd0, 0, 0, door_lvl); endtask
    task automatic do_tick();            step(0, 1, 0, 4'd0, 0, 0, door_lvl); endtask
    task automatic press_start();        step(0, 0, 0, 4'd0, 1, 0, door_lvl); endtask
    task automatic key(input logic [3:0] d); step(0, 0, 1, d, 0, 0, door_lvl); endtask
    task automatic stop_cycle();         step(0, 0, 0, 4'd0, 0, 1, door_lvl); endtask

    task automatic test_reset();
        do_clear();
        tests++; if (state_o !== 3'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", state_o); end
        tests++; if (time_bcd !== 16'h0000) begin fails++; $display("FAIL reset_time: got %h want 0000", time_bcd); end
        tests++; if (mag_on !== 1'b0 || beep !== 1'b0) begin fails++; $display("FAIL reset_outs: mag %b beep %b want 0 0", mag_on, beep); end
        $display("[TB] reset: state=%0d time=%h", state_o, time_bcd);
    endtask

    task automatic test_entry_cook();
        do_clear();
        key(4'd1); key(4'd3); key(4'd0);
        tests++; if (time_bcd !== 16'h0130) begin fails++; $display("FAIL entry_time: got %h want 0130", time_bcd); end
        tests++; if (state_o !== 3'd1) begin fails++; $display("FAIL entry_state: got %0d want 1", state_o); end
        press_start();
        tests++; if (state_o !== 3'd2 || mag_on !== 1'b1) begin fails++; $display("FAIL start_cook: state %0d mag %b want 2 1", state_o, mag_on); end
        for (int i = 0; i < 31; i++) do_tick();
        tests++; if (time_bcd !== 16'h0059) begin fails++; $display("FAIL countdown_31: got %h want 0059", time_bcd); end
        $display("[TB] entry_cook: time=%h state=%0d", time_bcd, state_o);
    endtask

    task automatic test_done_beep();
        do_clear();
        key(4'd2); press_start();
        do_tick();
        tests++; if (time_bcd !== 16'h0001) begin fails++; $display("FAIL done_first_tick: got %h want 0001", time_bcd); end
        do_tick();
        tests++; if (time_bcd !== 16'h0000 || state_o !== 3'd4) begin fails++; $display("FAIL done_entry: time %h state %0d want 0000 4", time_bcd, state_o); end
        tests++; if (mag_on !== 1'b0 || beep !== 1'b1) begin fails++; $display("FAIL done_outs: mag %b beep %b want 0 1", mag_on, beep); end
        do_tick(); do_tick();
        tests++; if (beep !== 1'b1 || state_o !== 3'd4) begin fails++; $display("FAIL beep_hold: beep %b state %0d want 1 4", beep, state_o); end
        press_start(); key(4'd7);
        tests++; if (state_o !== 3'd4 || time_bcd !== 16'h0000) begin fails++; $display("FAIL done_ignore: state %0d time %h want 4 0000", state_o, time_bcd); end
        do_tick();
        tests++; if (beep !== 1'b0 || state_o !== 3'd0) begin fails++; $display("FAIL beep_end: beep %b state %0d want 0 0", beep, state_o); end
        $display("[TB] done_beep: state=%0d beep=%b", state_o, beep);
    endtask

    task automatic test_door_pause();
        do_clear();
        key(4'd4); key(4'd5); press_start();
        door_lvl = 1'b1;
        idle();
        tests++; if (state_o !== 3'd3 || mag_on !== 1'b0) begin fails++; $display("FAIL door_pause: state %0d mag %b want 3 0", state_o, mag_on); end
        do_tick(); do_tick();
        tests++; if (time_bcd !== 16'h0045) begin fails++; $display("FAIL pause_hold: got %h want 0045", time_bcd); end
        press_start();
        tests++; if (state_o !== 3'd3) begin fails++; $display("FAIL door_start_block: got %0d want 3", state_o); end
        door_lvl = 1'b0;
        idle(); press_start();
        tests++; if (state_o !== 3'd2 || mag_on !== 1'b1 || time_bcd !== 16'h0045) begin fails++; $display("FAIL resume: state %0d mag %b time %h want 2 1 0045", state_o, mag_on, time_bcd); end
        $display("[TB] door_pause: state=%0d time=%h", state_o, time_bcd);
    endtask

    task automatic test_quick_stop();
        do_clear();
        press_start();
        tests++; if (time_bcd !== 16'h0030 || state_o !== 3'd2) begin fails++; $display("FAIL quick_start: time %h state %0d want 0030 2", time_bcd, state_o); end
        stop_cycle(); idle();
        tests++; if (state_o !== 3'd3 || time_bcd !== 16'h0030) begin fails++; $display("FAIL stop_pause: state %0d time %h want 3 0030", state_o, time_bcd); end
        stop_cycle(); idle();
        tests++; if (state_o !== 3'd0 || time_bcd !== 16'h0000) begin fails++; $display("FAIL stop_idle: state %0d time %h want 0 0000", state_o, time_bcd); end
        $display("[TB] quick_stop: state=%0d time=%h", state_o, time_bcd);
    endtask

    task automatic test_long_press_clear();
        do_clear();
        press_start();
        stop_cycle();
        tests++; if (state_o !== 3'd3) begin fails++; $display("FAIL long_c1: got %0d want 3", state_o); end
        stop_cycle(); stop_cycle();
        tests++; if (state_o !== 3'd3 || time_bcd !== 16'h0030) begin fails++; $display("FAIL long_c3: state %0d time %h want 3 0030", state_o, time_bcd); end
        stop_cycle();
        tests++; if (state_o !== 3'd0 || time_bcd !== 16'h0000) begin fails++; $display("FAIL long_c4: state %0d time %h want 0 0000", state_o, time_bcd); end
        idle(); press_start(); do_tick();
        do_clear();
        tests++; if (state_o !== 3'd0 || time_bcd !== 16'h0000 || mag_on !== 1'b0 || beep !== 1'b0) begin fails++; $display("FAIL clear_mid_cook: state %0d time %h mag %b beep %b want all 0", state_o, time_bcd, mag_on, beep); end
        $display("[TB] long_press_clear: state=%0d", state_o);
    endtask

    task automatic test_keys_edges();
        do_clear();
        key(4'd9); key(4'd9); key(4'd9); key(4'd9); key(4'd5);
        tests++; if (time_bcd !== 16'h9995) begin fails++; $display("FAIL five_keys: got %h want 9995", time_bcd); end
        key(4'hA);
        tests++; if (time_bcd !== 16'h9995) begin fails++; $display("FAIL key_above_9: got %h want 9995", time_bcd); end
        do_clear();
        key(4'd1); key(4'd0); key(4'd0); press_start(); do_tick();
        tests++; if (time_bcd !== 16'h0059) begin fails++; $display("FAIL minute_borrow: got %h want 0059", time_bcd); end
        do_clear();
        key(4'd1); key(4'd9); key(4'd0); press_start(); do_tick();
        tests++; if (time_bcd !== 16'h0189) begin fails++; $display("FAIL literal_secs: got %h want 0189", time_bcd); end
        do_clear();
        key(4'd0); press_start();
        tests++; if (state_o !== 3'd1 || time_bcd !== 16'h0000) begin fails++; $display("FAIL entry_zero_start: state %0d time %h want 1 0000", state_o, time_bcd); end
        $display("[TB] keys_edges: state=%0d time=%h", state_o, time_bcd);
    endtask

    task automatic test_random();
        bit sp = 1'b0;
        bit dr = 1'b0;
        int bad = 0;
        do_clear();
        for (int i = 0; i < 4000; i++) begin
            bit clr;
            bit tk;
            bit kv;
            bit st;
            logic [3:0] kd;
            clr = ($urandom_range(0, 399) == 0);
            tk  = ($urandom_range(0, 2) == 0);
            kv  = ($urandom_range(0, 4) == 0);
            kd  = 4'($urandom_range(0, 11));
            st  = ($urandom_range(0, 7) == 0);
            if (sp) sp = ($urandom_range(0, 2) != 0);
            else    sp = ($urandom_range(0, 14) == 0);
            if ($urandom_range(0, 19) == 0) dr = !dr;
            step(clr, tk, kv, kd, st, sp, dr);
            tests++;
            if (state_o !== 3'(m_state) || time_bcd !== model_time()
                || mag_on !== (m_state == S_COOK) || beep !== (m_state == S_DONE)) begin
                fails++;
                bad++;
                $display("FAIL random[%0d]: state %0d time %h mag %b beep %b want %0d %h %b %b",
                         i, state_o, time_bcd, mag_on, beep, m_state, model_time(),
                         m_state == S_COOK, m_state == S_DONE);
            end
        end
        $display("[TB] random: 4000 cycles, %0d disagreements", bad);
    endtask

    initial begin
        test_reset();
        test_entry_cook();
        test_done_beep();
        test_door_pause();
        test_quick_stop();
        test_long_press_clear();
        test_keys_edges();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
